// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier built around one shared add8 ripple adder.
// The product emerges after eight RUN steps and is flagged by a one-cycle done pulse.

module add8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [8:0] s
);

   logic [8:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      for (int i = 0; i < 8; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
      end
      s[8] = c[8];
   end

endmodule

module mul8_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic [15:0] p
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  mcand_q, mcand_d;
   logic [7:0]  hi_q, hi_d;
   logic [7:0]  lo_q, lo_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] p_q, p_d;

   logic [7:0]  addend;
   logic [8:0]  sum;
   logic [15:0] shifted;

   assign addend  = lo_q[0] ? mcand_q : 8'h00;
   // Adder carry lands in hi[7] as the 17-bit partial product shifts right.
   assign shifted = {sum, lo_q[7:1]};

   add8 u_add8 (
      .a (hi_q),
      .b (addend),
      .s (sum)
   );

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               mcand_d = a;
               lo_d    = b;
               hi_d    = 8'h00;
               cnt_d   = 3'd0;
               state_d = StRun;
            end
         end
         StRun: begin
            hi_d  = shifted[15:8];
            lo_d  = shifted[7:0];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               p_d     = shifted;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         mcand_q <= 8'h00;
         hi_q    <= 8'h00;
         lo_q    <= 8'h00;
         cnt_q   <= 3'd0;
         p_q     <= 16'h0000;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
      end
   end

   assign ready = (state_q == StIdle);
   assign busy  = (state_q == StRun) || (state_q == StDone);
   assign done  = (state_q == StDone);
   assign p     = p_q;

endmodule

// File: tb/tb_mul8_seq.sv
// Directed and random checks of mul8_seq: latency, product, hold, start-ignore, back-to-back,
// and asynchronous reset mid-operation.

module tb_mul8_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        ready;
   logic        busy;
   logic        done;
   logic [15:0] p;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mul8_seq dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .p     (p)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Accept one operation and follow it through done and the return to IDLE.
   task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp,
                         input string tag);
      int n;
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      check({tag, " ready"}, ready, 1);
      @(negedge clk);
      start = 1'b0;
      a     = ~av;
      b     = ~bv;
      n     = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, " latency"}, n, 8);
      check({tag, " p"}, p, exp);
      @(negedge clk);
      check({tag, " done fall"}, done, 0);
      check({tag, " ready back"}, ready, 1);
      check({tag, " p hold"}, p, exp);
   endtask

   initial begin
      int n_done;
      int first_done;
      int n;
      logic [7:0] ra;
      logic [7:0] rb;

      rst   = 1'b1;
      start = 1'b0;
      a     = 8'h00;
      b     = 8'h00;
      #12;
      check("reset ready", ready, 1);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset p", p, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      run_op(8'hFF, 8'hFF, 16'hFE01, "ffxff");
      run_op(8'h0D, 8'h0B, 16'h008F, "0dx0b");
      run_op(8'hAB, 8'h01, 16'h00AB, "abx01");
      @(negedge clk);
      check("hold between ops", p, 16'h00AB);
      run_op(8'h00, 8'h5A, 16'h0000, "00x5a");

      // start pulses during RUN and DONE must be ignored
      @(negedge clk);
      a     = 8'h0D;
      b     = 8'h0B;
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      n_done = 0;
      n      = 0;
      repeat (3) begin
         @(negedge clk);
         n++;
      end
      check("busy in run", busy, 1);
      a     = 8'hFF;
      b     = 8'hFF;
      start = 1'b1;
      @(negedge clk);
      n++;
      start = 1'b0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ignore run latency", n, 8);
      check("ignore run p", p, 16'h008F);
      n_done = 1;
      a      = 8'h22;
      b      = 8'h33;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ignore done ready", ready, 1);
      check("ignore done busy", busy, 0);
      repeat (12) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("ignore single pulse", n_done, 1);
      check("ignore p", p, 16'h008F);

      // start held high: accepts at T0, T10, T20
      @(negedge clk);
      a          = 8'd3;
      b          = 8'd5;
      start      = 1'b1;
      n_done     = 0;
      first_done = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (done) begin
            n_done++;
            check("held p", p, 16'h000F);
            check("held spacing", i, 9 + 10 * (n_done - 1));
            if (first_done == 0) first_done = i;
         end
      end
      start = 1'b0;
      check("held count", n_done, 3);
      check("held first", first_done, 9);

      // async reset at step 4 of 0x80*0x80
      @(negedge clk);
      a     = 8'h80;
      b     = 8'h80;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst ready", ready, 1);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst p", p, 16'h0000);
      @(negedge clk);
      rst    = 1'b0;
      n_done = 0;
      repeat (10) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("rst no done", n_done, 0);
      check("rst p stays", p, 16'h0000);
      run_op(8'h80, 8'h02, 16'h0100, "80x02");

      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         run_op(ra, rb, 16'(ra) * 16'(rb), "rand");
      end

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
